// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding, default baud
// divider for the 100 MHz / 19200 baud link, and the odd-parity helper.
package uart_pkg;

  localparam int unsigned BAUD_CYCLES_DEFAULT = 5208;
  localparam int unsigned TIMER_W_DEFAULT     = 13;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4,
    ST_ACK   = 3'd5
  } tx_state_t;

  // Parity bit that gives data plus parity an odd weight.
  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period timer: counts 0..BAUD_CYCLES-1 and wraps, flagging the last
// cycle of each bit period.
//   clk   - system clock
//   Reset - synchronous active-high reset
//   clr   - holds the count at zero (used while the link is idle)
//   done  - high on the final cycle of the current bit period
module uart_baud_timer
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_CYCLES = BAUD_CYCLES_DEFAULT,
  parameter int unsigned TIMER_W     = TIMER_W_DEFAULT
) (
  input  logic clk,
  input  logic Reset,
  input  logic clr,
  output logic done
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(BAUD_CYCLES - 1);

  logic [TIMER_W-1:0] count;

  // Wraps to zero on the same edge that done is seen.
  always_ff @(posedge clk) begin
    if (Reset || clr) begin
      count <= '0;
    end else if (done) begin
      count <= '0;
    end else begin
      count <= count + TIMER_W'(1);
    end
  end

  assign done = (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one 8-O-1 frame (start, 8 data LSB first, odd parity,
// stop) per accepted request.
//   clk   - system clock
//   Reset - synchronous active-high reset; aborts any frame, Sout high
//   Send  - request level, sampled only while idle
//   Din   - byte captured on the cycle the request is accepted
//   Sout  - registered serial line, idle high
//   Busy  - high whenever not idle
//   Sent  - completion handshake, high until Send is dropped
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_CYCLES = BAUD_CYCLES_DEFAULT,
  parameter int unsigned TIMER_W     = TIMER_W_DEFAULT
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Send,
  input  logic [7:0] Din,
  output logic       Sout,
  output logic       Busy,
  output logic       Sent
);

  localparam logic [2:0] IDLE  = ST_IDLE;
  localparam logic [2:0] START = ST_START;
  localparam logic [2:0] DATA  = ST_DATA;
  localparam logic [2:0] PAR   = ST_PAR;
  localparam logic [2:0] STOP  = ST_STOP;
  localparam logic [2:0] ACK   = ST_ACK;

  logic [2:0] state, state_next;
  logic [7:0] shreg, shreg_next;
  logic       par, par_next;
  logic [3:0] bit_cnt, bit_cnt_next;
  logic       sout_next, busy_next, sent_next;
  logic       timer_done;

  uart_baud_timer #(
    .BAUD_CYCLES(BAUD_CYCLES),
    .TIMER_W    (TIMER_W)
  ) u_timer (
    .clk  (clk),
    .Reset(Reset),
    .clr  (state == IDLE),
    .done (timer_done)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state   <= IDLE;
      shreg   <= '0;
      par     <= 1'b0;
      bit_cnt <= '0;
      Sout    <= 1'b1;
      Busy    <= 1'b0;
      Sent    <= 1'b0;
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      par     <= par_next;
      bit_cnt <= bit_cnt_next;
      Sout    <= sout_next;
      Busy    <= busy_next;
      Sent    <= sent_next;
    end
  end

  // Next state and datapath.
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    par_next     = par;
    bit_cnt_next = bit_cnt;
    case (state)
      IDLE: begin
        if (Send) begin
          state_next = START;
          shreg_next = Din;
          par_next   = odd_par(Din);
        end
      end
      START: begin
        if (timer_done) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (timer_done) begin
          shreg_next   = {1'b0, shreg[7:1]};
          bit_cnt_next = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            state_next = PAR;
          end
        end
      end
      PAR: begin
        if (timer_done) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (timer_done) begin
          state_next = ACK;
        end
      end
      ACK: begin
        if (!Send) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registers line up with
  // the state they describe; Sout never passes through combinational logic
  // after the flop.
  always_comb begin
    sout_next = 1'b1;
    busy_next = (state_next != IDLE);
    sent_next = (state_next == ACK);
    case (state_next)
      START:   sout_next = 1'b0;
      DATA:    sout_next = shreg_next[0];
      PAR:     sout_next = par_next;
      default: sout_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with a short bit period.
module tb_uart_tx;

  localparam int B  = 16;
  localparam int FL = 11 * B;

  logic       clk = 1'b0;
  logic       Reset;
  logic       Send;
  logic [7:0] Din;
  logic       Sout;
  logic       Busy;
  logic       Sent;

  int checks = 0;
  int passes = 0;

  uart_tx #(.BAUD_CYCLES(B), .TIMER_W(5)) dut (
    .clk  (clk),
    .Reset(Reset),
    .Send (Send),
    .Din  (Din),
    .Sout (Sout),
    .Busy (Busy),
    .Sent (Sent)
  );

  always #5 clk = ~clk;

  // Expected line bits, index 0 = start bit, 10 = stop bit.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += (d >> i) & 1;
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d, 1'b0};
  endfunction

  // Receiver view: even weight over data+parity is a parity error.
  function automatic logic rx_perr(input logic [10:0] f);
    int ones = 0;
    for (int i = 1; i <= 9; i++) ones += f[i];
    return (ones % 2) == 0;
  endfunction

  // Requests one frame and records the line for exactly FL+1 cycles.
  task automatic tx_frame(input logic [7:0] d, input int hold, input logic [7:0] din_after,
                          output bit fell, output logic [10:0] mid, output bit stable,
                          output int sent_at, output bit busy_ok);
    logic s [0:FL];
    @(negedge clk);
    Send = 1'b1;
    Din  = d;
    sent_at = -1;
    busy_ok = 1'b1;
    for (int c = 0; c <= FL; c++) begin
      @(negedge clk);
      if (c == 0) begin
        fell = (Sout === 1'b0);
        Din  = din_after;
      end
      if (c + 1 >= hold) Send = 1'b0;
      s[c] = Sout;
      if (Sent === 1'b1 && sent_at < 0) sent_at = c;
      if (c < FL && Busy !== 1'b1) busy_ok = 1'b0;
    end
    for (int k = 0; k < 11; k++) mid[k] = s[k * B + B / 2];
    stable = 1'b1;
    for (int c = 0; c < FL; c++) if (s[c] !== mid[c / B]) stable = 1'b0;
  endtask

  task automatic test_reset;
    bit quiet;
    Reset = 1'b1;
    Send  = 1'b0;
    Din   = 8'h00;
    repeat (5) @(negedge clk);
    checks++;
    if ({Sout, Busy, Sent} !== 3'b100) $display("FAIL reset_hold: Sout/Busy/Sent=%b expected 100", {Sout, Busy, Sent});
    else passes++;
    Reset = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({Sout, Busy, Sent} !== 3'b100) quiet = 1'b0;
    end
    checks++;
    if (!quiet) $display("FAIL reset_idle: outputs moved during 100 idle cycles, expected 100 throughout");
    else passes++;
  endtask

  task automatic test_frame_41;
    bit fell, stable, busy_ok;
    logic [10:0] mid;
    int sent_at;
    tx_frame(8'h41, 1, 8'h41, fell, mid, stable, sent_at, busy_ok);
    checks++;
    if (!fell) $display("FAIL f41_fall: Sout not low one cycle after Send");
    else passes++;
    checks++;
    if (mid !== 11'b11_0100_0001_0) $display("FAIL f41_bits: got %b expected %b", mid, 11'b11_0100_0001_0);
    else passes++;
    checks++;
    if (!stable) $display("FAIL f41_stable: Sout changed inside a bit period");
    else passes++;
    checks++;
    if (sent_at != FL) $display("FAIL f41_sent_rise: Sent rose at %0d expected %0d", sent_at, FL);
    else passes++;
    checks++;
    if (!busy_ok) $display("FAIL f41_busy: Busy dropped mid-frame");
    else passes++;
    @(negedge clk);
    checks++;
    if ({Sent, Busy, Sout} !== 3'b001) $display("FAIL f41_sent_fall: Sent/Busy/Sout=%b expected 001", {Sent, Busy, Sout});
    else passes++;
  endtask

  task automatic test_parity;
    logic [7:0] vals [3] = '{8'hFF, 8'h03, 8'h07};
    logic       pexp [3] = '{1'b1, 1'b1, 1'b0};
    bit fell, stable, busy_ok;
    logic [10:0] mid;
    int sent_at;
    for (int i = 0; i < 3; i++) begin
      tx_frame(vals[i], 1, vals[i], fell, mid, stable, sent_at, busy_ok);
      checks++;
      if (mid[9] !== pexp[i]) $display("FAIL parity_%h: parity bit %b expected %b", vals[i], mid[9], pexp[i]);
      else passes++;
      checks++;
      if (mid !== model_frame(vals[i])) $display("FAIL frame_%h: got %b expected %b", vals[i], mid, model_frame(vals[i]));
      else passes++;
    end
  endtask

  task automatic test_all_bytes;
    int off = $urandom_range(0, 255);
    bit fell, stable, busy_ok;
    logic [10:0] mid;
    int sent_at;
    logic [7:0] d;
    for (int i = 0; i < 256; i++) begin
      d = 8'(i + off);
      tx_frame(d, $urandom_range(1, 4), 8'($urandom), fell, mid, stable, sent_at, busy_ok);
      checks++;
      if (mid[8:1] !== d) $display("FAIL rx_data_%h: received %h expected %h", d, mid[8:1], d);
      else passes++;
      checks++;
      if (rx_perr(mid) !== 1'b0) $display("FAIL rx_parity_%h: parityErr=1 expected 0", d);
      else passes++;
      checks++;
      if (!(fell && stable && busy_ok && mid[0] === 1'b0 && mid[10] === 1'b1))
        $display("FAIL rx_framing_%h: fell=%0d stable=%0d busy=%0d start=%b stop=%b expected 1 1 1 0 1",
                 d, fell, stable, busy_ok, mid[0], mid[10]);
      else passes++;
      checks++;
      if (sent_at != FL) $display("FAIL rx_len_%h: Sent at %0d expected %0d", d, sent_at, FL);
      else passes++;
    end
  endtask

  task automatic test_send_held;
    bit fell, stable, busy_ok, held_ok;
    logic [10:0] mid;
    int sent_at;
    logic [7:0] d = 8'($urandom);
    tx_frame(d, 1 << 30, d, fell, mid, stable, sent_at, busy_ok);
    checks++;
    if (mid !== model_frame(d) || sent_at != FL)
      $display("FAIL held_frame: got %b at %0d expected %b at %0d", mid, sent_at, model_frame(d), FL);
    else passes++;
    held_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ({Sent, Busy, Sout} !== 3'b111) held_ok = 1'b0;
    end
    checks++;
    if (!held_ok) $display("FAIL held_ack: Sent/Busy/Sout left 111 while Send high");
    else passes++;
    Send = 1'b0;
    @(negedge clk);
    checks++;
    if ({Sent, Busy, Sout} !== 3'b001) $display("FAIL held_release: Sent/Busy/Sout=%b expected 001", {Sent, Busy, Sout});
    else passes++;
    d = 8'($urandom);
    tx_frame(d, 1, d, fell, mid, stable, sent_at, busy_ok);
    checks++;
    if (mid !== model_frame(d) || sent_at != FL || !stable)
      $display("FAIL held_second: got %b at %0d expected %b at %0d", mid, sent_at, model_frame(d), FL);
    else passes++;
  endtask

  task automatic test_reset_mid;
    bit fell, stable, busy_ok;
    logic [10:0] mid;
    int sent_at;
    @(negedge clk);
    Send = 1'b1;
    Din  = 8'($urandom) & 8'hEF;
    @(negedge clk);
    Send = 1'b0;
    repeat (5 * B + B / 2) @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({Sout, Busy, Sent} !== 3'b100) $display("FAIL reset_mid: Sout/Busy/Sent=%b expected 100", {Sout, Busy, Sent});
    else passes++;
    Reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({Sout, Busy, Sent} !== 3'b100) $display("FAIL reset_mid_idle: Sout/Busy/Sent=%b expected 100", {Sout, Busy, Sent});
    else passes++;
    tx_frame(8'hA5, 1, 8'hA5, fell, mid, stable, sent_at, busy_ok);
    checks++;
    if (mid !== model_frame(8'hA5) || !stable || !fell || sent_at != FL)
      $display("FAIL reset_mid_a5: got %b at %0d expected %b at %0d", mid, sent_at, model_frame(8'hA5), FL);
    else passes++;
  endtask

  task automatic test_din_change;
    bit fell, stable, busy_ok;
    logic [10:0] mid;
    int sent_at;
    tx_frame(8'hC3, 2, 8'h00, fell, mid, stable, sent_at, busy_ok);
    checks++;
    if (mid[8:1] !== 8'hC3) $display("FAIL din_change_data: got %h expected c3", mid[8:1]);
    else passes++;
    checks++;
    if (mid[9] !== 1'b1) $display("FAIL din_change_parity: got %b expected 1", mid[9]);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_frame_41();
    test_parity();
    test_send_held();
    test_reset_mid();
    test_din_change();
    test_all_bytes();
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
